// File: rtl/popcount24_pkg.sv
// Shared constants, state encoding and count saturation for the popcount24 unary transmitter.
package popcount24_pkg;

  localparam int N_BITS = 24;
  localparam int CNT_W  = $clog2(N_BITS + 1);

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(N_BITS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_BITS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Counts above the pattern length clamp to an all-ones frame.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > MAX_COUNT) ? MAX_COUNT : c;
  endfunction

endpackage

// File: rtl/popcount24_unary_gen.sv
// One step of unary pattern generation: thermometer by default, Bresenham spread when
// POPCOUNT24_SPREAD_EN is defined (pos is then the accumulator instead of the beat index).
module popcount24_unary_gen
  import popcount24_pkg::*;
(
  input  logic [CNT_W-1:0] n,
  input  logic [CNT_W-1:0] pos,
  output logic             gen_bit,
  output logic [CNT_W-1:0] pos_next
);

`ifdef POPCOUNT24_SPREAD_EN
  logic [CNT_W:0] sum;

  // A one is emitted each time the running total of n wraps past the frame length.
  always_comb begin
    sum      = {1'b0, pos} + {1'b0, n};
    gen_bit  = (sum >= (CNT_W+1)'(N_BITS));
    pos_next = gen_bit ? CNT_W'(sum - (CNT_W+1)'(N_BITS)) : sum[CNT_W-1:0];
  end
`else
  assign gen_bit  = (pos < n);
  assign pos_next = pos + 1'b1;
`endif

endmodule

// File: rtl/popcount24_unary_tx.sv
// Regenerates a 24-beat unary stream (and parallel word) from a popcount value.
// Optional macro POPCOUNT24_SPREAD_EN selects evenly spread ones instead of a thermometer.
module popcount24_unary_tx
  import popcount24_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_first,
  output logic              out_last,
  output logic [N_BITS-1:0] out_word,
  output logic              sat_flag
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  n_q, idx, idx_inc, n_in;
  logic [N_BITS-1:0] word_gen;
  logic [CNT_W-1:0]  chain [N_BITS+1];
  logic              accept, beat_xfer, next_bit;

  assign n_in      = sat_count(in_count);
  assign idx_inc   = idx + 1'b1;
  assign out_valid = (state == SEND);
  assign beat_xfer = out_valid & out_ready;
  assign in_ready  = (state == IDLE) | (beat_xfer & out_last);
  assign accept    = in_valid & in_ready;

  // The whole frame is unrolled once at accept so out_word is ready with beat 0.
  assign chain[0] = '0;
  for (genvar i = 0; i < N_BITS; i++) begin : g_word
    popcount24_unary_gen u_gen (
      .n        (n_in),
      .pos      (chain[i]),
      .gen_bit  (word_gen[i]),
      .pos_next (chain[i+1])
    );
  end

`ifdef POPCOUNT24_SPREAD_EN
  logic [CNT_W-1:0] acc, acc_step;
  logic             spread_bit;

  // acc holds the accumulator after the beat currently on the output.
  popcount24_unary_gen u_serial (
    .n        (n_q),
    .pos      (acc),
    .gen_bit  (spread_bit),
    .pos_next (acc_step)
  );
  assign next_bit = spread_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= chain[1];
    end else if (beat_xfer && !out_last) begin
      acc <= acc_step;
    end
  end
`else
  assign next_bit = (idx_inc < n_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SEND;
      SEND: if (beat_xfer && out_last) state_next = accept ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A stalled beat holds everything; a new accept takes priority over frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q       <= '0;
      idx       <= '0;
      out_bit   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_word  <= '0;
      sat_flag  <= 1'b0;
    end else if (accept) begin
      n_q       <= n_in;
      idx       <= '0;
      out_bit   <= word_gen[0];
      out_first <= 1'b1;
      out_last  <= 1'b0;
      out_word  <= word_gen;
      sat_flag  <= (in_count > MAX_COUNT);
    end else if (beat_xfer) begin
      if (out_last) begin
        idx       <= '0;
        out_bit   <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        idx       <= idx_inc;
        out_bit   <= next_bit;
        out_first <= 1'b0;
        out_last  <= (idx_inc == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_popcount24_unary_tx.sv
// Randomised self-checking bench for popcount24_unary_tx against a frame-level reference model.
module tb_popcount24_unary_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_count;
  logic        out_valid, out_ready, out_bit, out_first, out_last, sat_flag;
  logic [23:0] out_word;

  always #5 clk = ~clk;

  popcount24_unary_tx dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last),
    .out_word  (out_word),
    .sat_flag  (sat_flag)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: one frame in flight, beat k of a precomputed 24-bit pattern.
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_n = 0;
  logic [23:0] m_pat = '0;
  logic [23:0] m_word = '0;
  logic        m_sat = 1'b0;

  int offer_q[$];
  int ready_mode = 0;
  int cycle_no = 0;
  int rx_ones = 0, rx_beats = 0;
  int valid_run = 0, max_run = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      if (mismatched <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle_no);
    end
  endtask

  function automatic logic [23:0] refPattern(input int n);
    logic [23:0] p;
    for (int k = 0; k < 24; k++) begin
`ifdef POPCOUNT24_SPREAD_EN
      p[k] = (((k + 1) * n) / 24) != ((k * n) / 24);
`else
      p[k] = (k < n);
`endif
    end
    return p;
  endfunction

  task automatic applyStimulus(input int cnt);
    offer_q.push_back(cnt);
  endtask

  task automatic stepCycle();
    bit exp_ready, accept, xfer;
    int c;
    @(negedge clk);
    in_valid = (offer_q.size() > 0);
    in_count = in_valid ? 5'(offer_q[0]) : 5'($urandom_range(0, 31));
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cycle_no % 2 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    exp_ready = !m_busy || (out_ready && m_k == 23);
    checkOutput("in_ready",  in_ready,  exp_ready);
    checkOutput("out_valid", out_valid, m_busy);
    checkOutput("out_first", out_first, m_busy && m_k == 0);
    checkOutput("out_last",  out_last,  m_busy && m_k == 23);
    checkOutput("out_bit",   out_bit,   m_busy ? m_pat[m_k] : 1'b0);
    checkOutput("out_word",  out_word,  m_word);
    checkOutput("sat_flag",  sat_flag,  m_sat);

    if (out_valid) valid_run++;
    else valid_run = 0;
    if (valid_run > max_run) max_run = valid_run;

    if (out_valid && out_ready) begin
      rx_beats++;
      rx_ones += out_bit;
      if (out_last) begin
        checkOutput("frame_ones", rx_ones, m_n);
        checkOutput("frame_beats", rx_beats, 24);
        rx_ones = 0;
        rx_beats = 0;
      end
    end

    accept = in_valid && exp_ready;
    xfer = m_busy && out_ready;
    if (xfer) begin
      if (m_k == 23) m_busy = 1'b0;
      else m_k++;
    end
    if (accept) begin
      c = offer_q.pop_front();
      m_n = (c > 24) ? 24 : c;
      m_pat = refPattern(m_n);
      m_word = m_pat;
      m_sat = (c > 24);
      m_busy = 1'b1;
      m_k = 0;
    end
    cycle_no++;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((offer_q.size() > 0 || m_busy) && c < budget) begin
      stepCycle();
      c++;
    end
    checkOutput("drain_done", (offer_q.size() > 0 || m_busy), 0);
    stepCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    in_count = '0;
    out_ready = 1'b0;
    #12;
    checkOutput("rst_in_ready",  in_ready,  1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_bit",   out_bit,   0);
    checkOutput("rst_out_first", out_first, 0);
    checkOutput("rst_out_last",  out_last,  0);
    checkOutput("rst_out_word",  out_word,  0);
    checkOutput("rst_sat_flag",  sat_flag,  0);
    @(negedge clk);
    rst = 1'b0;

    ready_mode = 0;
    applyStimulus(5);
    drain(100);
`ifndef POPCOUNT24_SPREAD_EN
    checkOutput("word_n5", out_word, 24'h00001F);
`endif

    applyStimulus(31);
    drain(100);
    checkOutput("word_sat", out_word, 24'hFFFFFF);
    checkOutput("sat_n31", sat_flag, 1);

    applyStimulus(0);
    drain(100);
    checkOutput("word_n0", out_word, 0);
    checkOutput("sat_n0", sat_flag, 0);

    valid_run = 0;
    max_run = 0;
    applyStimulus(3);
    applyStimulus(20);
    drain(200);
    checkOutput("b2b_run", max_run, 48);
`ifndef POPCOUNT24_SPREAD_EN
    checkOutput("word_n20", out_word, 24'h0FFFFF);
`else
    applyStimulus(8);
    drain(100);
    checkOutput("word_spread8", out_word, 24'h924924);
    applyStimulus(12);
    drain(100);
    checkOutput("word_spread12", out_word, 24'hAAAAAA);
`endif

    ready_mode = 1;
    applyStimulus(7);
    drain(200);

    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      applyStimulus($urandom_range(0, 31));
      repeat ($urandom_range(0, 40)) stepCycle();
    end
    drain(6000);

    ready_mode = 0;
    applyStimulus(12);
    guard = 0;
    while (!(m_busy && m_k == 10) && guard < 100) begin
      stepCycle();
      guard++;
    end
    checkOutput("reach_beat10", (guard < 100), 1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready",  in_ready,  1);
    checkOutput("midrst_out_word",  out_word,  0);
    checkOutput("midrst_out_bit",   out_bit,   0);
    checkOutput("midrst_sat_flag",  sat_flag,  0);
    m_busy = 1'b0;
    m_k = 0;
    m_word = '0;
    m_sat = 1'b0;
    offer_q.delete();
    rx_ones = 0;
    rx_beats = 0;
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(12);
    drain(100);
`ifdef POPCOUNT24_SPREAD_EN
    checkOutput("word_after_rst", out_word, 24'hAAAAAA);
`else
    checkOutput("word_after_rst", out_word, 24'h000FFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
